// File: rtl/vl_rec_arbiter.sv
// vl_rec_arbiter: round-robin arbiter that merges NUM_REQ record senders
// onto one registered downstream channel, tagging the source of each record.
//
// Ports:
//   clk, reset     rising-edge clock, async active-high reset
//   req_valid      per-requester record valid
//   req_data       packed 5-bit records, requester i at [5i+4:5i]
//   req_ready      per-requester accept, one-hot or zero
//   out_valid      buffered record valid
//   out_data       buffered record {vl_bit, vl_arr[3:0]}
//   out_src        requester index that supplied out_data
//   out_ready      downstream accept
//   xfer_count     completed downstream transfers, wrapping
module vl_rec_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int SRC_W   = $clog2(NUM_REQ),
   parameter int CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [5*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 out_valid,
   output logic [4:0]           out_data,
   output logic [SRC_W-1:0]     out_src,
   input  logic                 out_ready,
   output logic [CNT_W-1:0]     xfer_count
);

   localparam int REC_W = 5;

   logic [SRC_W-1:0] last_q;
   logic [SRC_W-1:0] win;
   logic [SRC_W-1:0] idx;
   logic             found;
   logic             can_load;
   logic             load;
   logic             drain;
   logic [REC_W-1:0] win_rec;

   // Scan starts just past the last grant, so the most recently
   // served requester has the lowest priority this cycle.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = SRC_W'((int'(last_q) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign win_rec  = req_data[int'(win)*REC_W +: REC_W];
   assign can_load = !out_valid || out_ready;
   assign drain    = out_valid && out_ready;
   // Reset gates the handshake so no requester sees an accept
   // while the buffer is being cleared.
   assign load     = found && can_load && !reset;

   always_comb begin
      req_ready = '0;
      if (load) begin
         req_ready[win] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= '0;
         last_q     <= SRC_W'(NUM_REQ - 1);
         xfer_count <= '0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= win_rec;
            out_src   <= win;
            last_q    <= win;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
         if (drain) begin
            xfer_count <= xfer_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vl_rec_arbiter.sv
// tb_vl_rec_arbiter: scoreboard bench for the round-robin record arbiter.
// A second instance with a 3-bit counter exercises counter wrap.
module tb_vl_rec_arbiter;

   typedef struct packed {
      logic [1:0] src;
      logic [4:0] data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [19:0] req_data;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic [4:0]  out_data;
   logic [1:0]  out_src;
   logic        out_ready;
   logic [7:0]  xfer_count;

   logic [3:0]  req_ready2;
   logic        out_valid2;
   logic [4:0]  out_data2;
   logic [1:0]  out_src2;
   logic [2:0]  xfer_count2;

   exp_t sb[$];
   exp_t mon_e;
   int   total;
   int   bad;

   vl_rec_arbiter #(.NUM_REQ(4), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .xfer_count(xfer_count)
   );

   vl_rec_arbiter #(.NUM_REQ(4), .CNT_W(3)) dut_w (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready2),
      .out_valid (out_valid2),
      .out_data  (out_data2),
      .out_src   (out_src2),
      .out_ready (out_ready),
      .xfer_count(xfer_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every downstream transfer must match the oldest
   // expected record pushed by the stimulus tasks.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected src=%0d data=%b required none",
                     out_src, out_data);
         end else begin
            mon_e = sb.pop_front();
            if ({out_src, out_data} !== {mon_e.src, mon_e.data}) begin
               bad++;
               $display("FAIL sb_record got src=%0d data=%b required src=%0d data=%b",
                        out_src, out_data, mon_e.src, mon_e.data);
            end
         end
      end
   end

   function automatic logic [4:0] rr_rec(input int i);
      return 5'(i * 7 + 3);
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '0;
      @(posedge clk); #1;
      sb.delete();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 4'b1111;
      req_data = 20'hABCDE;
      out_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL rst_ready got %b required 0000", req_ready);
      end
      total++;
      if (out_valid !== 1'b0 || xfer_count !== 8'd0 || out_data !== 5'd0) begin
         bad++;
         $display("FAIL rst_state got v=%b c=%0d d=%b required 0 0 0",
                  out_valid, xfer_count, out_data);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      req_valid = '0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL idle got v=%b rdy=%b required 0 0000",
                     out_valid, req_ready);
         end
      end
      total++;
      if (xfer_count !== 8'd0) begin
         bad++;
         $display("FAIL idle_count got %0d required 0", xfer_count);
      end
   endtask

   task automatic test_single();
      req_data = 20'($urandom);
      req_data[14:10] = 5'b10110;
      req_valid = 4'b0100;
      out_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL single_ready got %b required 0100", req_ready);
      end
      sb.push_back('{src: 2'd2, data: 5'b10110});
      @(posedge clk); #1;
      req_valid = '0;
      total++;
      if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 5'b10110) begin
         bad++;
         $display("FAIL single_out got v=%b s=%0d d=%b required 1 2 10110",
                  out_valid, out_src, out_data);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || xfer_count !== 8'd1) begin
         bad++;
         $display("FAIL single_drain got v=%b c=%0d required 0 1",
                  out_valid, xfer_count);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 4; i++) req_data[i*5 +: 5] = rr_rec(i);
      req_valid = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sb.push_back('{src: 2'(k % 4), data: rr_rec(k % 4)});
      end
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (k == 7) req_valid = '0;
         total++;
         if (out_valid !== 1'b1 || out_src !== 2'(k % 4)) begin
            bad++;
            $display("FAIL rr_order[%0d] got v=%b s=%0d required 1 %0d",
                     k, out_valid, out_src, k % 4);
         end
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || xfer_count !== 8'd8) begin
         bad++;
         $display("FAIL rr_count got v=%b c=%0d required 0 8",
                  out_valid, xfer_count);
      end
   endtask

   task automatic test_backpressure();
      req_data = 20'($urandom);
      req_data[9:5] = 5'b01101;
      req_data[19:15] = 5'b10011;
      req_valid = 4'b1010;
      out_ready = 1'b0;
      #1;
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL bp_first got %b required 0010", req_ready);
      end
      sb.push_back('{src: 2'd1, data: 5'b01101});
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || out_src !== 2'd1 ||
             out_data !== 5'b01101 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL bp_hold[%0d] got v=%b s=%0d d=%b r=%b required 1 1 01101 0000",
                     k, out_valid, out_src, out_data, req_ready);
         end
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b1000) begin
         bad++;
         $display("FAIL bp_release got %b required 1000", req_ready);
      end
      sb.push_back('{src: 2'd3, data: 5'b10011});
      @(posedge clk); #1;
      req_valid = '0;
      total++;
      if (out_valid !== 1'b1 || out_src !== 2'd3) begin
         bad++;
         $display("FAIL bp_next got v=%b s=%0d required 1 3", out_valid, out_src);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || xfer_count !== 8'd10) begin
         bad++;
         $display("FAIL bp_count got v=%b c=%0d required 0 10",
                  out_valid, xfer_count);
      end
   endtask

   task automatic test_wrap();
      logic [4:0] d;
      do_reset();
      out_ready = 1'b1;
      req_data = 20'($urandom);
      d = 5'($urandom);
      req_data[4:0] = d;
      sb.push_back('{src: 2'd0, data: d});
      req_valid = 4'b0001;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #1;
         if (k == 8) begin
            req_valid = '0;
         end else begin
            d = 5'($urandom);
            req_data[4:0] = d;
            sb.push_back('{src: 2'd0, data: d});
         end
      end
      @(posedge clk); #1;
      total++;
      if (xfer_count2 !== 3'd1) begin
         bad++;
         $display("FAIL wrap_count3 got %0d required 1", xfer_count2);
      end
      total++;
      if (xfer_count !== 8'd9) begin
         bad++;
         $display("FAIL wrap_count8 got %0d required 9", xfer_count);
      end
   endtask

   task automatic test_async_reset();
      req_valid = 4'b0001;
      out_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = '0;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL ar_loaded got %b required 1", out_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      sb.delete();
      total++;
      if (out_valid !== 1'b0 || xfer_count !== 8'd0) begin
         bad++;
         $display("FAIL ar_async got v=%b c=%0d required 0 0",
                  out_valid, xfer_count);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) req_data[i*5 +: 5] = rr_rec(i);
      req_valid = 4'b1111;
      out_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL ar_first got %b required 0001", req_ready);
      end
      sb.push_back('{src: 2'd0, data: rr_rec(0)});
      @(posedge clk); #1;
      req_valid = '0;
      total++;
      if (out_valid !== 1'b1 || out_src !== 2'd0) begin
         bad++;
         $display("FAIL ar_out got v=%b s=%0d required 1 0", out_valid, out_src);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || xfer_count !== 8'd1) begin
         bad++;
         $display("FAIL ar_count got v=%b c=%0d required 0 1",
                  out_valid, xfer_count);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      req_valid = '0;
      req_data = '0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_async_reset();
      @(posedge clk); #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover got %0d required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
